beta_irq_ctrl: RTL and testbench
================================

# beta_irq_ctrl

Interrupt controller that drives the Beta processor's `IRQ` input from eight peripheral interrupt sources. It captures rising edges into a pending register, selects the highest-priority pending source, holds `IRQ` until the processor vectors to the exception address, then reports the serviced source number until software signals end-of-interrupt. It sits beside `Beta_MEM` in the top level. It watches the processor's instruction address bus to detect interrupt acceptance.

## Interface
Parameters:
- `NSRC`, 8, number of interrupt sources (1–8); `irq_id` is always 3 bits wide.
- `XADR`, 32'h80000008, instruction address that marks interrupt acceptance.
- `ACK_TIMEOUT`, 64, cycles `IRQ` may stay high without acceptance before the request is withdrawn (≥2).

Ports:
- `clk` in 1: single system clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `src` in NSRC: interrupt sources, synchronous to `clk`, rising-edge sensitive.
- `IAdr` in 32: instruction address from the Beta.
- `eoi` in 1: one-cycle end-of-interrupt pulse from software/decoder.
- `mask_we` in 1: mask write strobe (present only with `IRQ_MASK_EN`).
- `mask_wd` in NSRC: new mask value (present only with `IRQ_MASK_EN`).
- `IRQ` out 1: interrupt request to the Beta, registered.
- `irq_id` out 3: index of the source being requested or serviced, registered.
- `irq_active` out 1: high while a source is being serviced, registered.
- `pending` out NSRC: pending register, for software read-back.

## Operation
- Edge capture: `src_q` holds the previous-cycle `src`. `edge = src & ~src_q`. `pending |= edge` every cycle.
- Eligible set: `pending & mask`. Priority: lowest index wins.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if the eligible set is non-zero, latch the winning index into `irq_id`, set `IRQ`=1 and go to REQ.
  - REQ: `irq_id` is frozen. A higher-priority arrival waits.
    - If `IAdr == XADR`: `IRQ`=0, clear `pending[irq_id]`, `irq_active`=1, go to SERVICE.
    - Otherwise, if the timeout counter reaches `ACK_TIMEOUT`: `IRQ`=0, go to IDLE. Pending is kept, so the request is retried.
  - SERVICE: on `eoi`, `irq_active`=0 and go to IDLE. Nested interrupts are not supported.
- The timeout counter is `$clog2(ACK_TIMEOUT+1)` bits. It clears on entry to REQ and saturates; it never wraps.
- If a new edge arrives on the source being cleared in the same cycle, set wins and the bit stays pending.
- `eoi` is ignored in IDLE and REQ.
- If a pending bit is masked while in REQ, the request is still completed.

Reset values (asynchronous, `RESET_N`=0):
- `IRQ`=0, `irq_id`=0, `irq_active`=0, `pending`=0, `src_q`=0.
- FSM=IDLE, counter=0, mask=all ones.
- Reset asserted mid-request drops `IRQ` immediately. It is released synchronously at the next `clk` edge after `RESET_N` rises.

## Timing
- `src` is first sampled high at rising edge k, so the pending bit is set after edge k. `IRQ`=1 and `irq_id` are valid after edge k+1. That is a 2-cycle latency.
- `IAdr == XADR` is sampled at edge m. After edge m: `IRQ`=0, `irq_active`=1, and the pending bit is cleared.
- `eoi` is sampled at edge e. `irq_active`=0 after edge e. The earliest next `IRQ` is after edge e+1.
- Timeout: `IRQ` is high for exactly `ACK_TIMEOUT` cycles, then low for at least one cycle.

## Configuration
- `IRQ_MASK_EN` defined:
  - Adds `mask_we`/`mask_wd` and an NSRC-bit mask register, reset to all ones.
  - `mask_we` loads `mask_wd` at the next edge.
  - Masked sources still set pending but never raise `IRQ`.
- `IRQ_MASK_EN` undefined:
  - Mask ports are absent. The mask is the constant all-ones.

## Test plan
- Single source: pulse `src[3]`, then drive `IAdr`=32'h80000008 five cycles later. Required: `IRQ` rises 2 cycles after the pulse, `irq_id`=3, `IRQ` falls and `irq_active`=1 after the acceptance edge, `pending`=0. Then `eoi` gives `irq_active`=0.
- Priority: raise `src[5]` and `src[2]` together, then complete the acceptance and `eoi` handshake each time. Required: first `irq_id`=2, then a second request with `irq_id`=5.
- Timeout: raise `src[0]` and never present XADR, with `ACK_TIMEOUT`=64. Required: `IRQ` high exactly 64 cycles, low for 1 cycle, then high again; `pending[0]` stays 1 throughout.
- Set/clear collision: re-pulse `src[1]` in the same cycle as its acceptance. Required: `pending[1]`=1 afterwards, and a new request is raised after `eoi`.
- Reset mid-REQ: assert `RESET_N`=0 while `IRQ`=1. Required: `IRQ`, `pending` and `irq_active` all go to 0 immediately, without a clock edge.
- `IRQ_MASK_EN`: write mask=8'hFE, then pulse `src[0]`. Required: `pending[0]`=1 and `IRQ` stays 0. Then write mask=8'hFF: `IRQ` rises one cycle later.

Source files
------------

// File: rtl/beta_irq_ctrl.sv
// beta_irq_ctrl: edge-captured priority interrupt controller driving the Beta IRQ input.
// Define IRQ_MASK_EN to add a software-writable source mask (mask_we/mask_wd).
module beta_irq_ctrl #(
  parameter int          NSRC        = 8,
  parameter logic [31:0] XADR        = 32'h80000008,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            RESET_N,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     IAdr,
  input  logic            eoi,
`ifdef IRQ_MASK_EN
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
`endif
  output logic            IRQ,
  output logic [2:0]      irq_id,
  output logic            irq_active,
  output logic [NSRC-1:0] pending
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t          state, state_nxt;
  logic [NSRC-1:0] src_q, mask, elig, clr, pending_nxt;
  logic [CW-1:0]   cnt, cnt_inc, cnt_nxt;
  logic [2:0]      win, id_nxt;
  logic            irq_nxt, active_nxt, acc;
`ifdef IRQ_MASK_EN
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) mask <= '1;
    else if (mask_we) mask <= mask_wd;
`else
  assign mask = '1;
`endif
  assign elig = pending & mask;
  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) win = 3'(i);
  end
  assign cnt_inc = (cnt == CW'(ACK_TIMEOUT)) ? cnt : cnt + 1'b1;
  always_comb begin
    state_nxt  = state;
    irq_nxt    = IRQ;
    id_nxt     = irq_id;
    active_nxt = irq_active;
    cnt_nxt    = cnt;
    acc        = 1'b0;
    case (state)
      IDLE: if (|elig) begin
        state_nxt = REQ;
        irq_nxt   = 1'b1;
        id_nxt    = win;
        cnt_nxt   = '0;
      end
      REQ: if (IAdr == XADR) begin
        acc        = 1'b1;
        state_nxt  = SERVICE;
        irq_nxt    = 1'b0;
        active_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == CW'(ACK_TIMEOUT)) begin
          state_nxt = IDLE;
          irq_nxt   = 1'b0;
        end
      end
      SERVICE: if (eoi) begin
        state_nxt  = IDLE;
        active_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // A fresh edge on the bit being cleared keeps it pending.
  assign clr         = acc ? NSRC'(1) << irq_id : '0;
  assign pending_nxt = (pending & ~clr) | (src & ~src_q);
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      state      <= IDLE;
      IRQ        <= 1'b0;
      irq_id     <= '0;
      irq_active <= 1'b0;
      cnt        <= '0;
      pending    <= '0;
      src_q      <= '0;
    end else begin
      state      <= state_nxt;
      IRQ        <= irq_nxt;
      irq_id     <= id_nxt;
      irq_active <= active_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      src_q      <= src;
    end
endmodule

// File: tb/tb_beta_irq_ctrl.sv
// tb_beta_irq_ctrl: vector table plus directed timeout, reset and mask sequences for beta_irq_ctrl.
module tb_beta_irq_ctrl;
  localparam logic [31:0] XA = 32'h80000008;
  localparam logic [31:0] NA = 32'h80000004;
  logic clk = 1'b0, RESET_N = 1'b0, eoi = 1'b0, IRQ, irq_active;
  logic [7:0] src = '0, pending;
  logic [31:0] IAdr = NA;
  logic [2:0] irq_id;
  int checks = 0, errors = 0;
`ifdef IRQ_MASK_EN
  logic mask_we = 1'b0;
  logic [7:0] mask_wd = '1;
`endif
  beta_irq_ctrl dut (
    .clk(clk), .RESET_N(RESET_N), .src(src), .IAdr(IAdr), .eoi(eoi),
`ifdef IRQ_MASK_EN
    .mask_we(mask_we), .mask_wd(mask_wd),
`endif
    .IRQ(IRQ), .irq_id(irq_id), .irq_active(irq_active), .pending(pending)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] src;
    logic       acc;
    logic       eoi;
    logic       irq;
    logic [2:0] id;
    logic       act;
    logic [7:0] pend;
  } vec_t;
  vec_t vt [25];
  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int hi, bad;
    vt[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08};
    vt[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
    vt[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
    vt[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
    vt[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
    vt[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
    vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
    vt[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};
    vt[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00};
    vt[9]  = '{8'h24, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h24};
    vt[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h24};
    vt[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h20};
    vt[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h20};
    vt[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20};
    vt[14] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 8'h00};
    vt[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00};
    vt[16] = '{8'h02, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 8'h02};
    vt[17] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h02};
    vt[18] = '{8'h02, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 8'h02};
    vt[19] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h02};
    vt[20] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h02};
    vt[21] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h02};
    vt[22] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h02};
    vt[23] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00};
    vt[24] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00};
    #3;
    check("rst_irq", 0, 32'(IRQ), 32'd0);
    check("rst_id", 0, 32'(irq_id), 32'd0);
    check("rst_act", 0, 32'(irq_active), 32'd0);
    check("rst_pend", 0, 32'(pending), 32'd0);
    step;
    RESET_N = 1'b1;
    step;
    for (int i = 0; i < 25; i++) begin
      src  = vt[i].src;
      IAdr = vt[i].acc ? XA : NA;
      eoi  = vt[i].eoi;
      step;
      check("vec_irq", i, 32'(IRQ), 32'(vt[i].irq));
      check("vec_id", i, 32'(irq_id), 32'(vt[i].id));
      check("vec_act", i, 32'(irq_active), 32'(vt[i].act));
      check("vec_pend", i, 32'(pending), 32'(vt[i].pend));
    end
    src = '0; IAdr = NA; eoi = 1'b0;
    src = 8'h01;
    step;
    src = 8'h00;
    step;
    check("to_rise", 0, 32'(IRQ), 32'd1);
    hi = 0; bad = 0;
    while (IRQ && hi < 200) begin
      hi++;
      if (!pending[0]) bad++;
      step;
    end
    check("to_high_cycles", 0, 32'(hi), 32'd64);
    check("to_low", 0, 32'(IRQ), 32'd0);
    check("to_pend_low", 0, 32'(pending[0]), 32'd1);
    step;
    check("to_retry", 0, 32'(IRQ), 32'd1);
    check("to_pend_kept", 0, 32'(bad), 32'd0);
    IAdr = XA;
    step;
    IAdr = NA;
    eoi = 1'b1;
    step;
    eoi = 1'b0;
    check("to_done", 0, 32'(irq_active), 32'd0);
    src = 8'h10;
    step;
    src = 8'h00;
    step;
    check("mr_irq_before", 0, 32'(IRQ), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("mr_irq", 0, 32'(IRQ), 32'd0);
    check("mr_pend", 0, 32'(pending), 32'd0);
    check("mr_act", 0, 32'(irq_active), 32'd0);
    check("mr_id", 0, 32'(irq_id), 32'd0);
    step;
    RESET_N = 1'b1;
    step;
    check("mr_stay_idle", 0, 32'(IRQ), 32'd0);
`ifdef IRQ_MASK_EN
    mask_we = 1'b1; mask_wd = 8'hFE;
    step;
    mask_we = 1'b0; src = 8'h01;
    step;
    src = 8'h00;
    step;
    check("mk_pend", 0, 32'(pending), 32'h01);
    check("mk_irq_masked", 0, 32'(IRQ), 32'd0);
    step;
    check("mk_irq_masked2", 0, 32'(IRQ), 32'd0);
    mask_we = 1'b1; mask_wd = 8'hFF;
    step;
    mask_we = 1'b0;
    check("mk_irq_wr", 0, 32'(IRQ), 32'd0);
    step;
    check("mk_irq_rise", 0, 32'(IRQ), 32'd1);
    check("mk_id", 0, 32'(irq_id), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
